alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 143 ++++++++++++++
 tb/tb_alu_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of one shared, purely combinational ALU.
// Latency: request accepted in cycle N, RSP_VALID/RSP_DATA in cycle N+2, next accept at N+3 at the earliest.
// Backpressure: READY is asserted only in IDLE, for at most one requester; responses cannot be stalled.
//
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   REQn_VALID/READY         per-requester handshake (n = 0,1); READY is combinational
//   REQn_OP, REQn_A, REQn_B  per-requester opcode and operands
//   ALU_OP, ALU_A, ALU_B     registered drive to the shared ALU
//   ALU_OUT                  combinational result returned by the shared ALU
//   RSP_VALID                one-hot response strobe, bit n = result belongs to requester n
//   RSP_DATA                 registered ALU result
//   BUSY                     high whenever the FSM is not IDLE
//
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins
// every tie). Left undefined, ties are resolved round-robin.
module alu_arb #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             REQ0_VALID,
   input  logic             REQ1_VALID,
   output logic             REQ0_READY,
   output logic             REQ1_READY,
   input  logic [2:0]       REQ0_OP,
   input  logic [2:0]       REQ1_OP,
   input  logic [WIDTH-1:0] REQ0_A,
   input  logic [WIDTH-1:0] REQ0_B,
   input  logic [WIDTH-1:0] REQ1_A,
   input  logic [WIDTH-1:0] REQ1_B,
   output logic [2:0]       ALU_OP,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   input  logic [WIDTH-1:0] ALU_OUT,
   output logic [1:0]       RSP_VALID,
   output logic [WIDTH-1:0] RSP_DATA,
   output logic             BUSY
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_grant;   // requester owning the transaction in flight
   logic   w_accept;  // a handshake completes this cycle
   logic   w_sel;     // requester chosen this cycle (valid only with w_accept)

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Round-robin pointer; resets to 1 so requester 0 takes the first tie.
   logic   r_last;
`endif

   // Next state, arbitration and handshake outputs.
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_sel      = 1'b0;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      RSP_VALID  = 2'b00;
      case (r_state)
         IDLE: begin
            // READY is also masked by RST_N so nothing is acknowledged while reset is held.
            if (RST_N && (REQ0_VALID || REQ1_VALID)) begin
               w_accept = 1'b1;
               if (REQ0_VALID && REQ1_VALID) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                  w_sel = 1'b0;
`else
                  w_sel = ~r_last;
`endif
               end else begin
                  w_sel = REQ1_VALID;
               end
               REQ0_READY = ~w_sel;
               REQ1_READY = w_sel;
               w_next     = ISSUE;
            end
         end
         ISSUE: begin
            w_next = RESP;
         end
         RESP: begin
            RSP_VALID[r_grant] = 1'b1;
            w_next             = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign BUSY = (r_state != IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Operand capture on acceptance; held until the next acceptance.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ALU_OP  <= 3'd0;
         ALU_A   <= '0;
         ALU_B   <= '0;
         r_grant <= 1'b0;
      end else if (w_accept) begin
         ALU_OP  <= w_sel ? REQ1_OP : REQ0_OP;
         ALU_A   <= w_sel ? REQ1_A  : REQ0_A;
         ALU_B   <= w_sel ? REQ1_B  : REQ0_B;
         r_grant <= w_sel;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // The pointer flips on every acceptance, including uncontested ones.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_last <= 1'b1;
      end else if (w_accept) begin
         r_last <= ~r_last;
      end
   end
`endif

   // Result capture one cycle after issue; held until the next capture.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RSP_DATA <= '0;
      end else if (r_state == ISSUE) begin
         RSP_DATA <= ALU_OUT;
      end
   end

endmodule

// File: tb/tb_alu_arb.sv
module tb_alu_arb;

   localparam int W = 16;

   logic          CLK;
   logic          RST_N;
   logic          REQ0_VALID, REQ1_VALID;
   logic          REQ0_READY, REQ1_READY;
   logic [2:0]    REQ0_OP, REQ1_OP;
   logic [W-1:0]  REQ0_A, REQ0_B, REQ1_A, REQ1_B;
   logic [2:0]    ALU_OP;
   logic [W-1:0]  ALU_A, ALU_B, ALU_OUT;
   logic [1:0]    RSP_VALID;
   logic [W-1:0]  RSP_DATA;
   logic          BUSY;

   int n_chk = 0;
   int n_err = 0;

   alu_arb #(.WIDTH(W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
      .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
      .REQ0_OP(REQ0_OP), .REQ1_OP(REQ1_OP),
      .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
      .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OUT(ALU_OUT),
      .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Shared ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A<<B[3:0], 7 pass B.
   always_comb begin
      case (ALU_OP)
         3'd0:    ALU_OUT = ALU_A + ALU_B;
         3'd1:    ALU_OUT = ALU_A - ALU_B;
         3'd2:    ALU_OUT = ALU_A & ALU_B;
         3'd3:    ALU_OUT = ALU_A | ALU_B;
         3'd4:    ALU_OUT = ALU_A ^ ALU_B;
         3'd5:    ALU_OUT = ~ALU_A;
         3'd6:    ALU_OUT = ALU_A << ALU_B[3:0];
         default: ALU_OUT = ALU_B;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      REQ0_OP = 3'd0; REQ1_OP = 3'd0;
      REQ0_A = '0; REQ0_B = '0; REQ1_A = '0; REQ1_B = '0;
   endtask

   typedef struct {
      logic         v0;
      logic [2:0]   op0;
      logic [W-1:0] a0, b0;
      logic         v1;
      logic [2:0]   op1;
      logic [W-1:0] a1, b1;
      logic         exp_g;
      logic [W-1:0] exp_d;
   } vec_t;

   vec_t vecs[6];

   // One full transaction: accept in N, operands visible in N+1, response in N+2.
   task automatic run_vec(input vec_t v);
      @(negedge CLK);
      REQ0_VALID = v.v0; REQ0_OP = v.op0; REQ0_A = v.a0; REQ0_B = v.b0;
      REQ1_VALID = v.v1; REQ1_OP = v.op1; REQ1_A = v.a1; REQ1_B = v.b1;
      #1;
      chk("vec_ready", {30'd0, REQ1_READY, REQ0_READY}, v.exp_g ? 32'd2 : 32'd1);
      chk("vec_busy_idle", {31'd0, BUSY}, 32'd0);
      @(negedge CLK);
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      #1;
      chk("vec_busy_issue", {31'd0, BUSY}, 32'd1);
      chk("vec_alu_op", {29'd0, ALU_OP}, {29'd0, v.exp_g ? v.op1 : v.op0});
      chk("vec_alu_a", {16'd0, ALU_A}, {16'd0, v.exp_g ? v.a1 : v.a0});
      chk("vec_alu_b", {16'd0, ALU_B}, {16'd0, v.exp_g ? v.b1 : v.b0});
      chk("vec_ready_issue", {30'd0, REQ1_READY, REQ0_READY}, 32'd0);
      @(negedge CLK);
      #1;
      chk("vec_rsp_valid", {30'd0, RSP_VALID}, v.exp_g ? 32'd2 : 32'd1);
      chk("vec_rsp_data", {16'd0, RSP_DATA}, {16'd0, v.exp_d});
   endtask

   initial begin
      // Vector table; pointer starts at 1 after reset and toggles per acceptance.
      vecs[0] = '{1'b1, 3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h3030};
      vecs[1] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd0, 16'h1234, 16'h1111, 1'b1, 16'h2345};
      vecs[2] = '{1'b1, 3'd3, 16'h00FF, 16'h0F00, 1'b1, 3'd4, 16'h1111, 16'h2222, 1'b0, 16'h0FFF};
`ifdef ALU_ARB_FIXED_PRIO_EN
      vecs[3] = '{1'b1, 3'd3, 16'h00FF, 16'h0F00, 1'b1, 3'd4, 16'hAAAA, 16'hFFFF, 1'b0, 16'h0FFF};
`else
      vecs[3] = '{1'b1, 3'd3, 16'h00FF, 16'h0F00, 1'b1, 3'd4, 16'hAAAA, 16'hFFFF, 1'b1, 16'h5555};
`endif
      vecs[4] = '{1'b1, 3'd1, 16'h0005, 16'h0007, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'hFFFE};
      vecs[5] = '{1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd6, 16'h8001, 16'h0001, 1'b1, 16'h0002};

      // Reset state, with requests pending that must not be acknowledged.
      idle_inputs();
      RST_N = 1'b0;
      REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd0);
      chk("rst_rsp_valid", {30'd0, RSP_VALID}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_alu", {ALU_OP, ALU_A, ALU_B[12:0]}, 32'd0);
      chk("rst_alu_b", {16'd0, ALU_B}, 32'd0);
      chk("rst_rsp_data", {16'd0, RSP_DATA}, 32'd0);
      @(negedge CLK);
      idle_inputs();
      RST_N = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Hold: registered outputs keep the last transaction over idle cycles.
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         #1;
         chk("hold_alu_a", {16'd0, ALU_A}, 32'h8001);
         chk("hold_alu_b", {16'd0, ALU_B}, 32'h0001);
         chk("hold_rsp_data", {16'd0, RSP_DATA}, 32'h0002);
         chk("hold_rsp_valid", {30'd0, RSP_VALID}, 32'd0);
      end

      // Requester 1 raised while requester 0 is in flight waits until N+3.
      @(negedge CLK);
      REQ0_VALID = 1'b1; REQ0_OP = 3'd2; REQ0_A = 16'hF0F0; REQ0_B = 16'h3C3C;
      #1;
      chk("busy_n_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd1);
      @(negedge CLK);
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b1; REQ1_OP = 3'd7; REQ1_A = 16'h0000; REQ1_B = 16'hBEEF;
      #1;
      chk("busy_n1_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd0);
      @(negedge CLK);
      #1;
      chk("busy_n2_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd0);
      chk("busy_n2_rsp", {30'd0, RSP_VALID}, 32'd1);
      chk("busy_n2_data", {16'd0, RSP_DATA}, 32'h3030);
      @(negedge CLK);
      #1;
      chk("busy_n3_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd2);
      @(negedge CLK);
      REQ1_VALID = 1'b0;
      @(negedge CLK);
      #1;
      chk("busy_r1_rsp", {30'd0, RSP_VALID}, 32'd2);
      chk("busy_r1_data", {16'd0, RSP_DATA}, 32'hBEEF);

      // Reset asserted while in ISSUE discards the transaction.
      @(negedge CLK);
      REQ0_VALID = 1'b1; REQ0_OP = 3'd0; REQ0_A = 16'h1111; REQ0_B = 16'h2222;
      #1;
      chk("mid_accept", {30'd0, REQ1_READY, REQ0_READY}, 32'd1);
      @(negedge CLK);
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b1;
      RST_N = 1'b0;
      #1;
      chk("mid_busy", {31'd0, BUSY}, 32'd0);
      chk("mid_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd0);
      chk("mid_rsp_valid", {30'd0, RSP_VALID}, 32'd0);
      chk("mid_alu_op", {29'd0, ALU_OP}, 32'd0);
      chk("mid_alu_a", {16'd0, ALU_A}, 32'd0);
      chk("mid_alu_b", {16'd0, ALU_B}, 32'd0);
      chk("mid_rsp_data", {16'd0, RSP_DATA}, 32'd0);
      @(negedge CLK);
      #1;
      chk("mid_rst_ready", {30'd0, REQ1_READY, REQ0_READY}, 32'd0);
      idle_inputs();
      RST_N = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         #1;
         chk("mid_post_rsp", {30'd0, RSP_VALID}, 32'd0);
         chk("mid_post_busy", {31'd0, BUSY}, 32'd0);
      end

      // Fresh reset, both requesters valid continuously.
      @(negedge CLK);
      RST_N = 1'b0;
      REQ0_VALID = 1'b1; REQ0_OP = 3'd0; REQ0_A = 16'h0001; REQ0_B = 16'h0001;
      REQ1_VALID = 1'b1; REQ1_OP = 3'd0; REQ1_A = 16'h0002; REQ1_B = 16'h0002;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int c = 0; c < 12; c++) begin
         logic [1:0] exp_rdy;
         if (c > 0) @(negedge CLK);
         #1;
         exp_rdy = 2'b00;
         if (c % 3 == 0) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_rdy = 2'b01;
`else
            exp_rdy = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
         end
         chk($sformatf("tie_ready_c%0d", c), {30'd0, REQ1_READY, REQ0_READY}, {30'd0, exp_rdy});
         if (c % 3 == 2) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk($sformatf("tie_rsp_c%0d", c), {30'd0, RSP_VALID}, 32'd1);
`else
            chk($sformatf("tie_rsp_c%0d", c), {30'd0, RSP_VALID}, ((c / 3) % 2 == 0) ? 32'd1 : 32'd2);
`endif
         end
      end
      @(negedge CLK);
      idle_inputs();
      repeat (3) @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
